aer_pixel_ack_decoder: RTL and testbench

- Return path of the hierarchical pixel arbiter: consumes granted address-events (x = column, y = row) over a valid/ready handshake.
- Decodes each event into a one-hot per-pixel acknowledge on the ROWS x COLS array, indexed [row][col] to match the arbiter's req/gnt arrays.
- Holds the acknowledge until the addressed pixel withdraws its request (4-phase pixel handshake), then accepts the next event.
- Sits between the arbiter/readout chain and the pixel array; guarantees one acknowledged pixel at a time.

---
 rtl/aer_pixel_ack_decoder.sv | 182 ++++++++++++++++++
 tb/tb_aer_pixel_ack_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aer_pixel_ack_decoder.sv
// aer_pixel_ack_decoder: turns granted address-events into a one-hot pixel
// acknowledge and holds it until the pixel drops its request (4-phase).
// Ports: clk_i, reset_i (async, active-low); evt_valid_i/evt_x_i/evt_y_i/
// evt_ready_o event handshake; req_i live pixel requests; ack_o one-hot ack;
// busy_o (ACK or GAP), drop_o and timeout_o one-cycle status pulses.
// Optional: define AER_ACK_STATS_EN to add clr_stats_i and the saturating
// evt_cnt_o, drop_cnt_o and tmo_cnt_o event counters.
module aer_pixel_ack_decoder #(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       evt_valid_i,
    input  logic [ADDR_W-1:0]          evt_x_i,
    input  logic [ADDR_W-1:0]          evt_y_i,
    output logic                       evt_ready_o,
    input  logic [ROWS-1:0][COLS-1:0]  req_i,
    output logic [ROWS-1:0][COLS-1:0]  ack_o,
    output logic                       busy_o,
    output logic                       drop_o,
    output logic                       timeout_o
`ifdef AER_ACK_STATS_EN
    ,
    input  logic                       clr_stats_i,
    output logic [15:0]                evt_cnt_o,
    output logic [15:0]                drop_cnt_o,
    output logic [15:0]                tmo_cnt_o
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] x_q;
    logic [ADDR_W-1:0] y_q;

    logic accept;
    logic in_range;
    logic req_new;
    logic req_cur;
    logic hit;
    logic tmo_fire;

    // Mux-based selection so out-of-range addresses simply read as 0.
    function automatic logic pick(
        input logic [ROWS-1:0][COLS-1:0] r,
        input logic [ADDR_W-1:0]         y,
        input logic [ADDR_W-1:0]         x
    );
        logic v;
        v = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if (int'(y) == i && int'(x) == j) begin
                    v = r[i][j];
                end
            end
        end
        return v;
    endfunction

    function automatic logic [ROWS-1:0][COLS-1:0] onehot(
        input logic [ADDR_W-1:0] y,
        input logic [ADDR_W-1:0] x
    );
        logic [ROWS-1:0][COLS-1:0] v;
        v = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if (int'(y) == i && int'(x) == j) begin
                    v[i][j] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    assign evt_ready_o = (state == IDLE) && reset_i;
    assign accept      = evt_valid_i && evt_ready_o;
    assign in_range    = (int'(evt_y_i) < ROWS) && (int'(evt_x_i) < COLS);
    assign req_new     = pick(req_i, evt_y_i, evt_x_i);
    assign req_cur     = pick(req_i, y_q, x_q);
    assign hit         = in_range && req_new;
    // Release wins over timeout when both land in the same cycle.
    assign tmo_fire    = (state == ACK) && req_cur && (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            ack_o     <= '0;
            busy_o    <= 1'b0;
            drop_o    <= 1'b0;
            timeout_o <= 1'b0;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            drop_o    <= 1'b0;
            timeout_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x_q <= evt_x_i;
                        y_q <= evt_y_i;
                        if (hit) begin
                            state  <= ACK;
                            busy_o <= 1'b1;
                            ack_o  <= onehot(evt_y_i, evt_x_i);
                            cnt    <= '0;
                        end else begin
                            drop_o <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!req_cur) begin
                        state <= GAP;
                        ack_o <= '0;
                    end else if (tmo_fire) begin
                        state     <= GAP;
                        ack_o     <= '0;
                        timeout_o <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ack_o  <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef AER_ACK_STATS_EN
    logic evt_inc;
    logic drop_inc;

    assign evt_inc  = accept && hit;
    assign drop_inc = accept && !hit;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            evt_cnt_o  <= '0;
            drop_cnt_o <= '0;
            tmo_cnt_o  <= '0;
        end else if (clr_stats_i) begin
            evt_cnt_o  <= '0;
            drop_cnt_o <= '0;
            tmo_cnt_o  <= '0;
        end else begin
            if (evt_inc && evt_cnt_o != 16'hFFFF) begin
                evt_cnt_o <= evt_cnt_o + 16'd1;
            end
            if (drop_inc && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (tmo_fire && tmo_cnt_o != 16'hFFFF) begin
                tmo_cnt_o <= tmo_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aer_pixel_ack_decoder.sv
// tb_aer_pixel_ack_decoder: directed and randomized events against a
// transaction-level model of the pixel acknowledge decoder.
module tb_aer_pixel_ack_decoder;

    localparam int ROWS = 12;
    localparam int COLS = 10;
    localparam int AW   = 4;
    localparam int TMO  = 64;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      evt_valid = 1'b0;
    logic [AW-1:0]             evt_x = '0;
    logic [AW-1:0]             evt_y = '0;
    logic                      evt_ready;
    logic [ROWS-1:0][COLS-1:0] req = '0;
    logic [ROWS-1:0][COLS-1:0] ack;
    logic                      busy;
    logic                      drop;
    logic                      tmo;

    int checks = 0;
    int errors = 0;
    int n_evt  = 0;
    int n_drop = 0;
    int n_tmo  = 0;

`ifdef AER_ACK_STATS_EN
    logic        clr_stats = 1'b0;
    logic [15:0] evt_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] tmo_cnt;
`endif

    always #5 clk = ~clk;

    aer_pixel_ack_decoder #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .evt_valid_i (evt_valid),
        .evt_x_i     (evt_x),
        .evt_y_i     (evt_y),
        .evt_ready_o (evt_ready),
        .req_i       (req),
        .ack_o       (ack),
        .busy_o      (busy),
        .drop_o      (drop),
        .timeout_o   (tmo)
`ifdef AER_ACK_STATS_EN
        ,
        .clr_stats_i (clr_stats),
        .evt_cnt_o   (evt_cnt),
        .drop_cnt_o  (drop_cnt),
        .tmo_cnt_o   (tmo_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROWS-1:0][COLS-1:0] rand_req();
        logic [ROWS-1:0][COLS-1:0] r;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                r[i][j] = 1'($urandom_range(0, 1));
            end
        end
        return r;
    endfunction

    // Called at a negedge with the DUT idle. The pixel request drops at
    // the k-th ACK negedge, so the ack lives min(k, TMO) cycles and a
    // timeout is expected only when k > TMO.
    task automatic run_event(input int x, input int y, input bit want,
                             input int k, input bit hold);
        bit           inr;
        bit           to;
        int           h;
        logic [127:0] oh;
        inr       = (x < COLS) && (y < ROWS);
        evt_x     = AW'(x);
        evt_y     = AW'(y);
        evt_valid = 1'b1;
        req       = rand_req();
        if (inr) req[y][x] = want;
        check("ready_idle", 128'(evt_ready), 128'(1));
        @(negedge clk);
        if (!(inr && want)) begin
            evt_valid = 1'b0;
            n_drop++;
            check("drop_flags", 128'({drop, tmo, busy, evt_ready}),
                  128'(4'b1001));
            check("drop_noack", 128'(ack), 128'(0));
            @(negedge clk);
            check("drop_end", 128'({drop, busy, evt_ready}), 128'(3'b001));
            return;
        end
        n_evt++;
        h  = (k < TMO) ? k : TMO;
        to = (k > TMO);
        oh = 128'(1) << (y * COLS + x);
        evt_valid = hold;
        evt_x     = AW'($urandom);
        evt_y     = AW'($urandom);
        for (int i = 1; i <= h; i++) begin
            check("ack_hold", 128'(ack), oh);
            check("ack_flags", 128'({evt_ready, busy, drop, tmo}),
                  128'(4'b0100));
            req       = rand_req();
            req[y][x] = (i < k);
            @(negedge clk);
        end
        if (to) n_tmo++;
        check("gap_ack", 128'(ack), 128'(0));
        check("gap_flags", 128'({evt_ready, busy, drop, tmo}),
              128'({3'b010, to}));
        @(negedge clk);
        evt_valid = 1'b0;
        check("idle_flags", 128'({evt_ready, busy, drop, tmo}),
              128'(4'b1000));
        check("idle_ack", 128'(ack), 128'(0));
    endtask

    initial begin
        int r;
        int k;
        #1 rst_n = 1'b0;
        #2;
        check("rst_ack", 128'(ack), 128'(0));
        check("rst_flags", 128'({busy, drop, tmo}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_ready", 128'(evt_ready), 128'(1));
        @(negedge clk);

        run_event(5, 3, 1'b1, 3, 1'b0);
        run_event(2, 7, 1'b0, 1, 1'b0);
        run_event(3, 13, 1'b1, 1, 1'b0);
        run_event(12, 2, 1'b1, 1, 1'b0);
        run_event(0, 0, 1'b1, 200, 1'b0);
        run_event(9, 11, 1'b1, TMO, 1'b1);
        run_event(4, 6, 1'b1, TMO + 1, 1'b0);
        run_event(1, 1, 1'b1, 1, 1'b1);
        run_event(1, 2, 1'b1, 1, 1'b1);

        // Asynchronous reset while the ack is up.
        req       = '0;
        req[4][4] = 1'b1;
        evt_x     = 4'd4;
        evt_y     = 4'd4;
        evt_valid = 1'b1;
        @(negedge clk);
        evt_valid = 1'b0;
        check("pre_rst_ack", 128'(ack), 128'(1) << (4 * COLS + 4));
        #2 rst_n = 1'b0;
        #1 check("async_ack", 128'(ack), 128'(0));
        check("async_busy", 128'(busy), 128'(0));
        n_evt  = 0;
        n_drop = 0;
        n_tmo  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst", 128'({evt_ready, drop, tmo}), 128'(3'b100));
        @(negedge clk);
        check("post_rst2", 128'({evt_ready, busy, drop, tmo}),
              128'(4'b1000));

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       k = $urandom_range(1, 6);
            else if (r == 8) k = $urandom_range(TMO - 2, TMO + 2);
            else             k = 1;
            run_event($urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 4) != 0, k,
                      1'($urandom_range(0, 1)));
        end

`ifdef AER_ACK_STATS_EN
        check("stat_evt", 128'(evt_cnt), 128'(n_evt));
        check("stat_drop", 128'(drop_cnt), 128'(n_drop));
        check("stat_tmo", 128'(tmo_cnt), 128'(n_tmo));
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check("stat_clr", 128'({evt_cnt, drop_cnt, tmo_cnt}), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
